// File: rtl/mmcm_ps_pkg.sv
// Shared state type and constants for the MMCM fine phase-shift sequencer.
// Optional feature macro used by the controller: MMCM_PS_SHORTEST_PATH_EN.
package mmcm_ps_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        STEP,
        WAIT,
        FIN,
        ERR
    } ps_state_t;

    localparam logic PS_INC = 1'b1;
    localparam logic PS_DEC = 1'b0;

    // One fine step is 1/56 of a VCO period; the output period spans CLKOUT0_DIVIDE VCO periods.
    localparam int unsigned PS_STEPS_PER_VCO = 56;
    localparam int unsigned CLKOUT0_DIVIDE   = 10;
    localparam int unsigned PERIOD_STEPS_DEF = PS_STEPS_PER_VCO * CLKOUT0_DIVIDE;

endpackage

// File: rtl/mmcm_ps_phase_acc.sv
// Phase register that steps by +/-1 modulo PERIOD_STEPS, with a synchronous clear
// used when the MMCM loses lock and discards its accumulated shift.
module mmcm_ps_phase_acc
    import mmcm_ps_pkg::*;
#(
    parameter int unsigned PHASE_W      = 16,
    parameter int unsigned PERIOD_STEPS = PERIOD_STEPS_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_step,
    input  logic               i_inc,
    output logic [PHASE_W-1:0] o_phase
);

    localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(PERIOD_STEPS - 1);

    logic [PHASE_W-1:0] r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
        end else if (i_step) begin
            if (i_inc == PS_INC) begin
                r_phase <= (r_phase == P_LAST) ? '0 : r_phase + 1'b1;
            end else begin
                r_phase <= (r_phase == '0) ? P_LAST : r_phase - 1'b1;
            end
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/mmcm_ps_ctrl.sv
// MMCM dynamic fine phase-shift sequencer: walks the tracked phase to an absolute target,
// one PSEN/PSDONE pair at a time. Define MMCM_PS_SHORTEST_PATH_EN to allow wrap-around moves.
module mmcm_ps_ctrl
    import mmcm_ps_pkg::*;
#(
    parameter int unsigned PHASE_W      = 16,
    parameter int unsigned PERIOD_STEPS = PERIOD_STEPS_DEF,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic               psclk,
    input  logic               resen,
    input  logic               locked,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PHASE_W-1:0] req_target,
    output logic               psen,
    output logic               psincdec,
    input  logic               psdone,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               fault
);

    localparam int unsigned        TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [PHASE_W-1:0] P_LAST   = PHASE_W'(PERIOD_STEPS - 1);

    ps_state_t          r_state;
    ps_state_t          w_next;
    logic [PHASE_W-1:0] r_target;
    logic [PHASE_W:0]   r_steps;
    logic               r_dir;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_fault;
    logic               r_locked_d;

    logic [PHASE_W-1:0] w_phase;
    logic               w_step;
    logic               w_accept;
    logic               w_tmo_hit;
    logic [PHASE_W:0]   w_t;
    logic [PHASE_W:0]   w_p;
    logic [PHASE_W:0]   w_plan_steps;
    logic               w_plan_dir;

    assign w_accept  = (r_state == IDLE) && req_valid && locked;
    assign w_tmo_hit = locked && (r_state == WAIT) && !psdone && (r_tmo == TMO_LAST);

    assign w_t = {1'b0, r_target};
    assign w_p = {1'b0, w_phase};

`ifdef MMCM_PS_SHORTEST_PATH_EN
    localparam logic [PHASE_W:0] P_EXT  = (PHASE_W + 1)'(PERIOD_STEPS);
    localparam logic [PHASE_W:0] P_HALF = (PHASE_W + 1)'(PERIOD_STEPS / 2);

    logic [PHASE_W:0] w_up;

    // Forward distance modulo the period; ties and short forward distances go up.
    always_comb begin
        w_up         = (w_t >= w_p) ? (w_t - w_p) : (w_t + P_EXT - w_p);
        w_plan_dir   = PS_INC;
        w_plan_steps = w_up;
        if (w_up > P_HALF) begin
            w_plan_dir   = PS_DEC;
            w_plan_steps = P_EXT - w_up;
        end
    end
`else
    always_comb begin
        w_plan_dir   = PS_DEC;
        w_plan_steps = w_p - w_t;
        if (w_t > w_p) begin
            w_plan_dir   = PS_INC;
            w_plan_steps = w_t - w_p;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next = PLAN;
            PLAN: begin
                if (r_target > P_LAST)        w_next = ERR;
                else if (w_plan_steps == '0)  w_next = FIN;
                else                          w_next = STEP;
            end
            STEP: w_next = WAIT;
            WAIT: begin
                if (psdone) begin
                    w_step = 1'b1;
                    w_next = (r_steps == (PHASE_W + 1)'(1)) ? FIN : STEP;
                end else if (r_tmo == TMO_LAST) begin
                    w_next = ERR;
                end
            end
            FIN:     w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Lock loss abandons the move silently from any state.
        if (!locked) begin
            w_next = IDLE;
            w_step = 1'b0;
        end
    end

    always_ff @(posedge psclk or negedge resen) begin
        if (!resen) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge psclk or negedge resen) begin
        if (!resen) begin
            r_target   <= '0;
            r_steps    <= '0;
            r_dir      <= PS_DEC;
            r_tmo      <= '0;
            r_fault    <= 1'b0;
            r_locked_d <= 1'b0;
        end else begin
            r_locked_d <= locked;
            if (w_accept) r_target <= req_target;
            if (r_state == PLAN) begin
                r_dir   <= w_plan_dir;
                r_steps <= w_plan_steps;
            end
            if (w_step) r_steps <= r_steps - 1'b1;
            if (r_state == STEP)      r_tmo <= '0;
            else if (r_state == WAIT) r_tmo <= r_tmo + 1'b1;
            if (locked && !r_locked_d) r_fault <= 1'b0;
            else if (w_tmo_hit)        r_fault <= 1'b1;
        end
    end

    mmcm_ps_phase_acc #(
        .PHASE_W      (PHASE_W),
        .PERIOD_STEPS (PERIOD_STEPS)
    ) u_phase_acc (
        .i_clk   (psclk),
        .i_rst_n (resen),
        .i_clr   (!locked),
        .i_step  (w_step),
        .i_inc   (r_dir),
        .o_phase (w_phase)
    );

    assign phase     = w_phase;
    assign req_ready = locked && (r_state == IDLE);
    assign psen      = locked && (r_state == STEP);
    assign psincdec  = r_dir;
    assign busy      = (r_state == PLAN) || (r_state == STEP) || (r_state == WAIT);
    assign done      = locked && (r_state == FIN);
    assign err       = locked && (r_state == ERR);
    assign fault     = r_fault;

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// Self-checking bench for mmcm_ps_ctrl with a behavioural MMCM phase-shift responder.
// Honours MMCM_PS_SHORTEST_PATH_EN in its reference model.
module tb_mmcm_ps_ctrl;

    localparam int P   = 560;
    localparam int TMO = 64;

    logic        psclk;
    logic        resen;
    logic        locked;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_target;
    logic        psen;
    logic        psincdec;
    logic        psdone;
    logic [15:0] phase;
    logic        busy;
    logic        done;
    logic        err;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;

    int mmcm_lat    = 12;
    bit withhold    = 0;
    int cd          = 0;
    bit outstanding = 0;
    bit prev_psen   = 0;
    int mon_inc     = 0;
    int mon_dec     = 0;
    int m_phase     = 0;

    mmcm_ps_ctrl #(
        .PHASE_W      (16),
        .PERIOD_STEPS (560),
        .TIMEOUT      (64)
    ) dut (
        .psclk      (psclk),
        .resen      (resen),
        .locked     (locked),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .psen       (psen),
        .psincdec   (psincdec),
        .psdone     (psdone),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fault      (fault)
    );

    initial psclk = 1'b0;
    always #5 psclk = ~psclk;

    // MMCM model: answers each PSEN with one PSDONE mmcm_lat cycles later, and
    // checks that PSEN pulses never overlap or arrive while one is outstanding.
    initial begin
        psdone = 1'b0;
        forever begin
            @(negedge psclk);
            psdone = 1'b0;
            if (locked !== 1'b1 || resen !== 1'b1) begin
                cd = 0; outstanding = 0; prev_psen = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        psdone = 1'b1;
                        outstanding = 0;
                    end
                end
                if (psen === 1'b1) begin
                    vectors++;
                    if (prev_psen || outstanding) begin
                        miscompares++;
                        $display("FAIL psen_spacing: prev_psen=%0b outstanding=%0b, required both 0", prev_psen, outstanding);
                    end
                    outstanding = 1;
                    if (psincdec) mon_inc++; else mon_dec++;
                    if (!withhold) cd = mmcm_lat;
                end
                prev_psen = (psen === 1'b1);
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference move: step counts in each direction to go from 'from' to 'to'.
    function automatic void exp_move(input int from, input int to, output int inc, output int dec);
        int up;
        inc = 0; dec = 0;
`ifdef MMCM_PS_SHORTEST_PATH_EN
        up = ((to - from) % P + P) % P;
        if (up <= P / 2) inc = up; else dec = P - up;
`else
        up = 0;
        if (to > from) inc = to - from; else dec = from - to;
`endif
    endfunction

    task automatic run_req(input int tgt, input int bound, output int k, output bit got_done, output bit got_err);
        @(negedge psclk);
        mon_inc = 0; mon_dec = 0;
        req_target = 16'(tgt);
        req_valid  = 1'b1;
        @(negedge psclk);
        req_valid = 1'b0;
        k = 1;
        while (done !== 1'b1 && err !== 1'b1 && k < bound) begin
            @(negedge psclk);
            k++;
        end
        got_done = (done === 1'b1);
        got_err  = (err === 1'b1);
    endtask

    task automatic test_reset();
        resen = 1'b0; locked = 1'b0; req_valid = 1'b0; req_target = '0;
        #23;
        vectors++;
        if ({psen, psincdec, busy, done, err, fault, req_ready} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required 0000000", {psen, psincdec, busy, done, err, fault, req_ready});
        end
        vectors++;
        if (phase !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_phase: got %0d, required 0", phase);
        end
        @(negedge psclk);
        resen = 1'b1; locked = 1'b1;
        @(negedge psclk);
        @(negedge psclk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: req_ready=%b busy=%b, required 1/0", req_ready, busy);
        end
        m_phase = 0;
    endtask

    task automatic test_move(input string name, input int tgt, input int lat);
        int k, inc, dec;
        bit gd, ge;
        mmcm_lat = lat;
        exp_move(m_phase, tgt, inc, dec);
        run_req(tgt, 2 + (inc + dec) * (lat + 1) + 50, k, gd, ge);
        vectors++;
        if (gd !== 1'b1 || ge !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: done=%b err=%b, required 1/0", name, gd, ge);
        end
        vectors++;
        if (mon_inc != inc || mon_dec != dec) begin
            miscompares++;
            $display("FAIL %s_pulses: inc=%0d dec=%0d, required inc=%0d dec=%0d", name, mon_inc, mon_dec, inc, dec);
        end
        vectors++;
        if (phase !== 16'(tgt)) begin
            miscompares++;
            $display("FAIL %s_phase: got %0d, required %0d", name, phase, tgt);
        end
        vectors++;
        if (k != 2 + (inc + dec) * (lat + 1)) begin
            miscompares++;
            $display("FAIL %s_latency: done at cycle %0d, required %0d", name, k, 2 + (inc + dec) * (lat + 1));
        end
        @(negedge psclk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse_width: done=%b busy=%b after pulse, required 0/0", name, done, busy);
        end
        m_phase = tgt;
    endtask

    task automatic test_bad_target();
        int k;
        bit gd, ge;
        int tgts[4];
        tgts[0] = P;
        for (int i = 1; i < 4; i++) tgts[i] = int'($urandom_range(561, 65535));
        for (int i = 0; i < 4; i++) begin
            run_req(tgts[i], 20, k, gd, ge);
            vectors++;
            if (ge !== 1'b1 || gd !== 1'b0 || k != 2) begin
                miscompares++;
                $display("FAIL bad_target: tgt=%0d err=%b done=%b cycle=%0d, required err at cycle 2", tgts[i], ge, gd, k);
            end
            vectors++;
            if (mon_inc + mon_dec != 0 || phase !== 16'(m_phase)) begin
                miscompares++;
                $display("FAIL bad_target_nomove: pulses=%0d phase=%0d, required 0 and %0d", mon_inc + mon_dec, phase, m_phase);
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        bit gd, ge;
        int tgt;
        withhold = 1;
        tgt = (m_phase + 1) % P;
        run_req(tgt, 200, k, gd, ge);
        withhold = 0;
        vectors++;
        if (ge !== 1'b1 || k < 2 + TMO || k > 2 + TMO + 2) begin
            miscompares++;
            $display("FAIL timeout_err: err=%b at cycle %0d, required err near cycle %0d", ge, k, 2 + TMO + 1);
        end
        vectors++;
        if (mon_inc + mon_dec != 1 || phase !== 16'(m_phase)) begin
            miscompares++;
            $display("FAIL timeout_nomove: pulses=%0d phase=%0d, required 1 and %0d", mon_inc + mon_dec, phase, m_phase);
        end
        @(negedge psclk);
        vectors++;
        if (fault !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_fault: fault=%b err=%b, required 1/0", fault, err);
        end
        run_req(m_phase, 20, k, gd, ge);
        vectors++;
        if (gd !== 1'b1 || k != 2 || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_accepts: done=%b cycle=%0d fault=%b, required 1, 2, 1", gd, k, fault);
        end
        @(negedge psclk);
        locked = 1'b0;
        @(negedge psclk);
        vectors++;
        if (phase !== 16'd0 || req_ready !== 1'b0 || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL unlock_state: phase=%0d req_ready=%b fault=%b, required 0/0/1", phase, req_ready, fault);
        end
        locked = 1'b1;
        @(negedge psclk);
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL relock_fault_clear: fault=%b, required 0", fault);
        end
        m_phase = 0;
    endtask

    task automatic test_lock_loss();
        int k;
        bit seen;
        mmcm_lat = 12;
        @(negedge psclk);
        mon_inc = 0; mon_dec = 0;
        req_target = 16'd10;
        req_valid  = 1'b1;
        @(negedge psclk);
        req_valid = 1'b0;
        k = 0;
        while (phase !== 16'd3 && k < 200) begin
            @(negedge psclk);
            k++;
        end
        vectors++;
        if (phase !== 16'd3) begin
            miscompares++;
            $display("FAIL lockloss_reach3: phase=%0d, required 3", phase);
        end
        locked = 1'b0;
        #1;
        vectors++;
        if (psen !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL lockloss_psen: psen=%b req_ready=%b, required 0/0", psen, req_ready);
        end
        @(negedge psclk);
        vectors++;
        if (phase !== 16'd0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL lockloss_state: phase=%0d busy=%b req_ready=%b, required 0/0/0", phase, busy, req_ready);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge psclk);
            if (done === 1'b1 || err === 1'b1 || psen === 1'b1 || req_ready === 1'b1) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL lockloss_quiet: done/err/psen/req_ready seen while unlocked, required none");
        end
        locked = 1'b1;
        @(negedge psclk);
        vectors++;
        if (req_ready !== 1'b1 || phase !== 16'd0) begin
            miscompares++;
            $display("FAIL relock_ready: req_ready=%b phase=%0d, required 1/0", req_ready, phase);
        end
        m_phase = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_move("random", int'($urandom_range(0, P - 1)), int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_move("target5", 5, 12);
        test_move("back_to_0", 0, 12);
        test_move("target555", 555, 12);
        test_move("goto7", 7, 3);
        test_move("same7", 7, 3);
        test_bad_target();
        test_timeout();
        test_lock_loss();
        test_move("wrap_up", 558, 2);
        test_move("wrap_cross", 2, 2);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
